ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Consumer end of the ID/EX pipeline register: takes the registered ID_EX_* bundle and performs operand forwarding, ALU-control decode, ALU execution and branch resolution.
- Captures all results into an internal EX/MEM pipeline register (one-cycle latency).
- Sits between the ID/EX register and data memory. Its EX/MEM outputs feed the MEM stage and also feed back into its own forwarding path.

Parameters:
- XLEN, 64, datapath width (ALU, PC, immediate, register data).
- REGW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ID_EX_Inst  in  4  {funct7[5], funct3}.
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  in  REGW  register indices.
- ID_EX_ReadData1, ID_EX_ReadData2  in  XLEN  register-file operands.
- ID_EX_imm_data  in  XLEN  sign-extended immediate.
- ID_EX_PC_Out  in  XLEN  PC of the instruction.
- ID_EX_ALUsrc  in  1  1 = operand B is the immediate.
- ID_EX_ALUop  in  2  ALU class.
- ID_EX_Branch, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg  in  1  control bits.
- MEM_WB_RegWrite  in  1  writeback enable.
- MEM_WB_rd  in  REGW  writeback destination.
- MEM_WB_WriteData  in  XLEN  writeback value.
- ex_flush  in  1  squash the instruction currently in EX.
- EX_MEM_ALU_Result  out  XLEN  registered ALU result.
- EX_MEM_WriteData  out  XLEN  registered forwarded rs2 (store data).
- EX_MEM_rd  out  REGW  registered destination.
- EX_MEM_BranchTarget  out  XLEN  registered PC + (imm<<1).
- EX_MEM_PCSrc  out  1  registered branch-taken.
- EX_MEM_Zero  out  1  registered ALU result == 0.
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg  out  1  registered control bits.

Behaviour:
- Reset: while reset==0, every output is 0, asynchronously and immediately, including mid-operation. The first capture happens on the first rising clk edge after reset returns to 1.
- Latency: ID_EX_* sampled at edge N appears on the EX_MEM_* outputs after edge N+1. One instruction per cycle; no stall input.
- Forwarding, operand A (rs1):
  - If EX_MEM_RegWrite and EX_MEM_rd!=0 and EX_MEM_rd==ID_EX_rs1: use EX_MEM_ALU_Result.
  - Else if MEM_WB_RegWrite and MEM_WB_rd!=0 and MEM_WB_rd==ID_EX_rs1: use MEM_WB_WriteData.
  - Else: use ID_EX_ReadData1.
  - When both sources match, EX/MEM wins.
- Forwarding, rs2: identical rules give fwdB.
  - Operand B = ID_EX_imm_data if ALUsrc, else fwdB.
  - EX_MEM_WriteData always captures fwdB.
- Load-use hazards are stalled upstream. Forwarding EX_MEM_ALU_Result of a load is not this block's concern.
- ALU control:
  - ALUop 00: add.
  - ALUop 01: sub.
  - ALUop 10 (R-type), by Inst: 0000 add, 1000 sub, 0001 sll, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 0010 slt.
  - ALUop 11 (I-type): Inst[3] is ignored except funct3=101 (Inst[3]=1 gives sra, else srl). Otherwise decodes as ALUop 10 with Inst[3]=0.
  - Any undefined code: add.
- Arithmetic rules:
  - Shifts use B[5:0].
  - slt is a signed compare with result 0 or 1.
  - add/sub wrap modulo 2^XLEN with no overflow flag.
- Branch resolution:
  - Taken = ID_EX_Branch AND the condition on Inst[2:0]: 000 A==B, 001 A!=B, 100 A<B signed, 101 A>=B signed. Other codes give not taken.
  - Compare uses the forwarded operands (fwdA, fwdB), never the immediate.
  - BranchTarget = ID_EX_PC_Out + (imm<<1), wrapping.
- ex_flush:
  - When high at the capture edge: EX_MEM_MemRead, MemWrite, RegWrite, MemtoReg and PCSrc capture 0.
  - Datapath outputs capture normally (don't-care).
  - A flushed slot never forwards, because RegWrite=0.
- Simultaneous ex_flush with a taken branch: flush wins and PCSrc=0.

Test Plan:
- Reset: drive reset=0 mid-stream with a pending ADD -> all EX_MEM_* are 0 immediately. Release -> the next edge captures the current inputs.
- R-type, no hazards: ALUop=10, Inst=1000, RD1=10, RD2=3, RegWrite=1, rd=5 -> after one edge ALU_Result=7, rd=5, RegWrite=1, Zero=0.
- Forwarding priority: previous instruction writes x3=100 (in EX/MEM) while MEM_WB has rd=3 data=55. Current ADD x4=x3+x3 -> result 200. With EX/MEM rd=0 instead -> result 110.
- Immediate and shifts: ALUop=11, Inst=1101, A=-16, imm=2 -> -4. Inst=0101 -> 0x3FFF_FFFF_FFFF_FFFC.
- Branch: Branch=1, Inst=000, A=B=9, PC=0x100, imm=8 -> PCSrc=1, BranchTarget=0x110, Zero=1. Inst=100, A=-1, B=1 -> PCSrc=1. Inst=101 -> PCSrc=0.
- Flush: taken BEQ or a store with ex_flush=1 -> PCSrc, MemWrite, RegWrite, MemRead, MemtoReg all 0. The following dependent instruction gets no EX/MEM forward.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// The master side is the pipeline around the stage. It drives the ID/EX
// register, the MEM/WB writeback path and the flush, and it consumes the
// EX/MEM register. The slave side is the execute stage itself.
interface ex_stage_if #(
  parameter int XLEN = 64,
  parameter int REGW = 5
);
  // ID/EX pipeline register contents
  logic [3:0]      ID_EX_Inst;        // {funct7[5], funct3}
  logic [REGW-1:0] ID_EX_rs1;
  logic [REGW-1:0] ID_EX_rs2;
  logic [REGW-1:0] ID_EX_rd;
  logic [XLEN-1:0] ID_EX_ReadData1;
  logic [XLEN-1:0] ID_EX_ReadData2;
  logic [XLEN-1:0] ID_EX_imm_data;
  logic [XLEN-1:0] ID_EX_PC_Out;
  logic            ID_EX_ALUsrc;
  logic [1:0]      ID_EX_ALUop;
  logic            ID_EX_Branch;
  logic            ID_EX_MemRead;
  logic            ID_EX_MemWrite;
  logic            ID_EX_RegWrite;
  logic            ID_EX_MemtoReg;

  // Writeback path, used as the older forwarding source
  logic            MEM_WB_RegWrite;
  logic [REGW-1:0] MEM_WB_rd;
  logic [XLEN-1:0] MEM_WB_WriteData;

  // Squash for the instruction currently in EX
  logic            ex_flush;

  // EX/MEM pipeline register contents
  logic [XLEN-1:0] EX_MEM_ALU_Result;
  logic [XLEN-1:0] EX_MEM_WriteData;
  logic [REGW-1:0] EX_MEM_rd;
  logic [XLEN-1:0] EX_MEM_BranchTarget;
  logic            EX_MEM_PCSrc;
  logic            EX_MEM_Zero;
  logic            EX_MEM_MemRead;
  logic            EX_MEM_MemWrite;
  logic            EX_MEM_RegWrite;
  logic            EX_MEM_MemtoReg;

  modport master (
    output ID_EX_Inst, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_imm_data, ID_EX_PC_Out,
           ID_EX_ALUsrc, ID_EX_ALUop, ID_EX_Branch, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg,
           MEM_WB_RegWrite, MEM_WB_rd, MEM_WB_WriteData, ex_flush,
    input  EX_MEM_ALU_Result, EX_MEM_WriteData, EX_MEM_rd, EX_MEM_BranchTarget,
           EX_MEM_PCSrc, EX_MEM_Zero, EX_MEM_MemRead, EX_MEM_MemWrite,
           EX_MEM_RegWrite, EX_MEM_MemtoReg
  );

  modport slave (
    input  ID_EX_Inst, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_imm_data, ID_EX_PC_Out,
           ID_EX_ALUsrc, ID_EX_ALUop, ID_EX_Branch, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg,
           MEM_WB_RegWrite, MEM_WB_rd, MEM_WB_WriteData, ex_flush,
    output EX_MEM_ALU_Result, EX_MEM_WriteData, EX_MEM_rd, EX_MEM_BranchTarget,
           EX_MEM_PCSrc, EX_MEM_Zero, EX_MEM_MemRead, EX_MEM_MemWrite,
           EX_MEM_RegWrite, EX_MEM_MemtoReg
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage. It forwards operands from EX/MEM and MEM/WB, decodes the ALU
// control, runs the ALU and resolves branches. All results land in an EX/MEM
// register, so results appear one cycle after the ID/EX inputs are sampled.
module ex_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR,  ALU_AND, ALU_SLT
  } alu_op_e;

  // R-type decode of {funct7[5], funct3}. Unlisted codes fall back to add.
  function automatic alu_op_e decode_rtype(input logic [3:0] code);
    case (code)
      4'b0000: return ALU_ADD;
      4'b1000: return ALU_SUB;
      4'b0001: return ALU_SLL;
      4'b0100: return ALU_XOR;
      4'b0101: return ALU_SRL;
      4'b1101: return ALU_SRA;
      4'b0110: return ALU_OR;
      4'b0111: return ALU_AND;
      4'b0010: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // EX/MEM register state
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_write_data;
  logic [XLEN-1:0] ex_mem_branch_target;
  logic [REGW-1:0] ex_mem_rd;
  logic            ex_mem_pc_src;
  logic            ex_mem_zero;
  logic            ex_mem_mem_read;
  logic            ex_mem_mem_write;
  logic            ex_mem_reg_write;
  logic            ex_mem_mem_to_reg;

  // Combinational datapath
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] branch_target;
  logic [5:0]      shamt;
  logic [2:0]      funct3;
  alu_op_e         alu_op;
  logic            branch_cond;
  logic            ex_mem_fwd_ok;
  logic            mem_wb_fwd_ok;

  assign funct3        = bus.ID_EX_Inst[2:0];
  assign ex_mem_fwd_ok = ex_mem_reg_write && (ex_mem_rd != '0);
  assign mem_wb_fwd_ok = bus.MEM_WB_RegWrite && (bus.MEM_WB_rd != '0);

  // Operand forwarding. The younger EX/MEM result wins over MEM/WB.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    fwd_a = bus.ID_EX_ReadData1;
    fwd_b = bus.ID_EX_ReadData2;
    if (ex_mem_fwd_ok && (ex_mem_rd == bus.ID_EX_rs1))
      fwd_a = ex_mem_alu_result;
    else if (mem_wb_fwd_ok && (bus.MEM_WB_rd == bus.ID_EX_rs1))
      fwd_a = bus.MEM_WB_WriteData;
    if (ex_mem_fwd_ok && (ex_mem_rd == bus.ID_EX_rs2))
      fwd_b = ex_mem_alu_result;
    else if (mem_wb_fwd_ok && (bus.MEM_WB_rd == bus.ID_EX_rs2))
      fwd_b = bus.MEM_WB_WriteData;
  end

  assign op_b  = bus.ID_EX_ALUsrc ? bus.ID_EX_imm_data : fwd_b;
  assign shamt = op_b[5:0];

  // ALU control. For I-type, funct7[5] only selects between sra and srl.
  always_comb begin
    alu_op = ALU_ADD;
    case (bus.ID_EX_ALUop)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      2'b10: alu_op = decode_rtype(bus.ID_EX_Inst);
      default: begin
        if (funct3 == 3'b101)
          alu_op = bus.ID_EX_Inst[3] ? ALU_SRA : ALU_SRL;
        else
          alu_op = decode_rtype({1'b0, funct3});
      end
    endcase
  end

  // ALU. Arithmetic wraps, shifts use the low six bits of operand B.
  always_comb begin
    alu_result = fwd_a + op_b;
    case (alu_op)
      ALU_ADD: alu_result = fwd_a + op_b;
      ALU_SUB: alu_result = fwd_a - op_b;
      ALU_SLL: alu_result = fwd_a << shamt;
      ALU_XOR: alu_result = fwd_a ^ op_b;
      ALU_SRL: alu_result = fwd_a >> shamt;
      ALU_SRA: alu_result = $signed(fwd_a) >>> shamt;
      ALU_OR:  alu_result = fwd_a | op_b;
      ALU_AND: alu_result = fwd_a & op_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_result = fwd_a + op_b;
    endcase
  end

  // Branch condition. It compares the forwarded registers, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = (fwd_a == fwd_b);
      3'b001:  branch_cond = (fwd_a != fwd_b);
      3'b100:  branch_cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
      default: branch_cond = 1'b0;
    endcase
  end

  assign branch_target = bus.ID_EX_PC_Out + (bus.ID_EX_imm_data << 1);

  // EX/MEM register. A flush clears the control bits so the slot has no side
  // effects and never forwards. The datapath fields still capture.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every flop here is reset, because the outputs must read zero while reset is held.
    if (!reset) begin
      ex_mem_alu_result    <= '0;
      ex_mem_write_data    <= '0;
      ex_mem_branch_target <= '0;
      ex_mem_rd            <= '0;
      ex_mem_pc_src        <= 1'b0;
      ex_mem_zero          <= 1'b0;
      ex_mem_mem_read      <= 1'b0;
      ex_mem_mem_write     <= 1'b0;
      ex_mem_reg_write     <= 1'b0;
      ex_mem_mem_to_reg    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      ex_mem_alu_result    <= alu_result;
      ex_mem_write_data    <= fwd_b;
      ex_mem_branch_target <= branch_target;
      ex_mem_rd            <= bus.ID_EX_rd;
      ex_mem_zero          <= (alu_result == '0);
      ex_mem_pc_src        <= bus.ID_EX_Branch   && branch_cond && !bus.ex_flush;
      ex_mem_mem_read      <= bus.ID_EX_MemRead  && !bus.ex_flush;
      ex_mem_mem_write     <= bus.ID_EX_MemWrite && !bus.ex_flush;
      ex_mem_reg_write     <= bus.ID_EX_RegWrite && !bus.ex_flush;
      ex_mem_mem_to_reg    <= bus.ID_EX_MemtoReg && !bus.ex_flush;
    end
  end

  assign bus.EX_MEM_ALU_Result   = ex_mem_alu_result;
  assign bus.EX_MEM_WriteData    = ex_mem_write_data;
  assign bus.EX_MEM_BranchTarget = ex_mem_branch_target;
  assign bus.EX_MEM_rd           = ex_mem_rd;
  assign bus.EX_MEM_PCSrc        = ex_mem_pc_src;
  assign bus.EX_MEM_Zero         = ex_mem_zero;
  assign bus.EX_MEM_MemRead      = ex_mem_mem_read;
  assign bus.EX_MEM_MemWrite     = ex_mem_mem_write;
  assign bus.EX_MEM_RegWrite     = ex_mem_reg_write;
  assign bus.EX_MEM_MemtoReg     = ex_mem_mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage. It runs directed scenarios and then random
// instruction streams against a behavioural model of the execute stage.
module tb_ex_stage;
  localparam int XLEN = 64;
  localparam int REGW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ex_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();
  ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Free-running clock with rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  inst;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rd1, rd2, imm, pc;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        branch, mr, mw, rw, m2r;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
  } stim_t;

  typedef struct {
    logic [63:0] alu, wdata, target;
    logic [4:0]  rd;
    logic        pcsrc, zero, mr, mw, rw, m2r;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t model;
  exp_t zeros;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".alu"},    bus.EX_MEM_ALU_Result,        model.alu);
    check({tag, ".wdata"},  bus.EX_MEM_WriteData,         model.wdata);
    check({tag, ".target"}, bus.EX_MEM_BranchTarget,      model.target);
    check({tag, ".rd"},     64'(bus.EX_MEM_rd),           64'(model.rd));
    check({tag, ".pcsrc"},  64'(bus.EX_MEM_PCSrc),        64'(model.pcsrc));
    check({tag, ".zero"},   64'(bus.EX_MEM_Zero),         64'(model.zero));
    check({tag, ".mr"},     64'(bus.EX_MEM_MemRead),      64'(model.mr));
    check({tag, ".mw"},     64'(bus.EX_MEM_MemWrite),     64'(model.mw));
    check({tag, ".rw"},     64'(bus.EX_MEM_RegWrite),     64'(model.rw));
    check({tag, ".m2r"},    64'(bus.EX_MEM_MemtoReg),     64'(model.m2r));
  endtask

  // Operand source as seen by the instruction in EX. The previous
  // instruction's result is newest, then the writeback value, then the
  // register file.
  function automatic logic [63:0] operand(input logic [4:0] idx, input logic [63:0] rf,
                                          input stim_t s, input exp_t prev);
    if (prev.rw && prev.rd != 0 && prev.rd == idx) return prev.alu;
    if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == idx) return s.wb_data;
    return rf;
  endfunction

  // Expected EX/MEM contents after one instruction, given the previous contents.
  function automatic exp_t ref_model(input stim_t s, input exp_t prev);
    exp_t        r;
    logic [63:0] a, fb, b, res;
    longint      sa, sb, sfb;
    int          sh;
    logic [2:0]  f3;
    logic        f7, taken;
    a   = operand(s.rs1, s.rd1, s, prev);
    fb  = operand(s.rs2, s.rd2, s, prev);
    b   = s.alusrc ? s.imm : fb;
    sa  = a;
    sb  = b;
    sfb = fb;
    sh  = int'(b[5:0]);
    f3  = s.inst[2:0];
    f7  = s.inst[3];
    if (s.aluop == 2'b11 && f3 != 3'b101) f7 = 1'b0;
    res = a + b;
    if (s.aluop == 2'b01) res = a - b;
    else if (s.aluop[1]) begin
      case (f3)
        3'd0:    res = f7 ? a - b : a + b;
        3'd1:    res = f7 ? a + b : a << sh;
        3'd2:    res = f7 ? a + b : ((sa < sb) ? 64'd1 : 64'd0);
        3'd4:    res = f7 ? a + b : a ^ b;
        3'd5:    res = f7 ? 64'(sa >>> sh) : a >> sh;
        3'd6:    res = f7 ? a + b : a | b;
        3'd7:    res = f7 ? a + b : a & b;
        default: res = a + b;
      endcase
    end
    case (f3)
      3'd0:    taken = (a == fb);
      3'd1:    taken = (a != fb);
      3'd4:    taken = (sa < sfb);
      3'd5:    taken = (sa >= sfb);
      default: taken = 1'b0;
    endcase
    r.alu    = res;
    r.wdata  = fb;
    r.target = s.pc + (s.imm << 1);
    r.rd     = s.rd;
    r.zero   = (res == 0);
    r.pcsrc  = s.branch && taken && !s.flush;
    r.mr     = s.mr  && !s.flush;
    r.mw     = s.mw  && !s.flush;
    r.rw     = s.rw  && !s.flush;
    r.m2r    = s.m2r && !s.flush;
    return r;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{inst: '0, rs1: '0, rs2: '0, rd: '0, rd1: '0, rd2: '0, imm: '0, pc: '0,
          alusrc: 1'b0, aluop: '0, branch: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0,
          m2r: 1'b0, wb_rw: 1'b0, wb_rd: '0, wb_data: '0, flush: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s         = nop();
    s.inst    = 4'($urandom_range(0, 15));
    s.rs1     = 5'($urandom_range(0, 3));
    s.rs2     = 5'($urandom_range(0, 3));
    s.rd      = 5'($urandom_range(0, 3));
    s.rd1     = {$urandom, $urandom};
    s.rd2     = ($urandom_range(0, 3) == 0) ? s.rd1 : {$urandom, $urandom};
    s.imm     = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
    s.pc      = {$urandom, $urandom};
    s.alusrc  = 1'($urandom_range(0, 1));
    s.aluop   = 2'($urandom_range(0, 3));
    s.branch  = 1'($urandom_range(0, 1));
    s.mr      = 1'($urandom_range(0, 1));
    s.mw      = 1'($urandom_range(0, 1));
    s.rw      = 1'($urandom_range(0, 1));
    s.m2r     = 1'($urandom_range(0, 1));
    s.wb_rw   = 1'($urandom_range(0, 1));
    s.wb_rd   = 5'($urandom_range(0, 3));
    s.wb_data = {$urandom, $urandom};
    s.flush   = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.ID_EX_Inst       = s.inst;
    bus.ID_EX_rs1        = s.rs1;
    bus.ID_EX_rs2        = s.rs2;
    bus.ID_EX_rd         = s.rd;
    bus.ID_EX_ReadData1  = s.rd1;
    bus.ID_EX_ReadData2  = s.rd2;
    bus.ID_EX_imm_data   = s.imm;
    bus.ID_EX_PC_Out     = s.pc;
    bus.ID_EX_ALUsrc     = s.alusrc;
    bus.ID_EX_ALUop      = s.aluop;
    bus.ID_EX_Branch     = s.branch;
    bus.ID_EX_MemRead    = s.mr;
    bus.ID_EX_MemWrite   = s.mw;
    bus.ID_EX_RegWrite   = s.rw;
    bus.ID_EX_MemtoReg   = s.m2r;
    bus.MEM_WB_RegWrite  = s.wb_rw;
    bus.MEM_WB_rd        = s.wb_rd;
    bus.MEM_WB_WriteData = s.wb_data;
    bus.ex_flush         = s.flush;
  endtask

  // Called just after a falling edge. It drives one instruction, lets one
  // rising edge capture it, and compares everything at the next falling edge.
  task automatic cycle(input stim_t s, input string tag);
    drive(s);
    model = ref_model(s, model);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    stim_t s;
    zeros = '{alu: '0, wdata: '0, target: '0, rd: '0, pcsrc: 1'b0, zero: 1'b0,
              mr: 1'b0, mw: 1'b0, rw: 1'b0, m2r: 1'b0};
    model = zeros;
    drive(nop());
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    reset = 1'b1;

    // R-type sub without hazards
    s = nop(); s.aluop = 2'b10; s.inst = 4'b1000; s.rs1 = 5'd1; s.rs2 = 5'd2;
    s.rd1 = 64'd10; s.rd2 = 64'd3; s.rw = 1'b1; s.rd = 5'd5;
    cycle(s, "rsub");
    check("rsub_result", bus.EX_MEM_ALU_Result, 64'd7);
    check("rsub_zero", 64'(bus.EX_MEM_Zero), 64'd0);

    // Forwarding priority: EX/MEM beats MEM/WB
    s = nop(); s.alusrc = 1'b1; s.rd1 = 64'd100; s.rd = 5'd3; s.rw = 1'b1;
    cycle(s, "x3_100");
    s = nop(); s.aluop = 2'b10; s.rs1 = 5'd3; s.rs2 = 5'd3; s.rd1 = 64'd1; s.rd2 = 64'd1;
    s.rd = 5'd4; s.rw = 1'b1; s.wb_rw = 1'b1; s.wb_rd = 5'd3; s.wb_data = 64'd55;
    cycle(s, "fwd_exmem");
    check("fwd_exmem_result", bus.EX_MEM_ALU_Result, 64'd200);
    s = nop(); s.alusrc = 1'b1; s.rd1 = 64'd100; s.rd = 5'd0; s.rw = 1'b1;
    cycle(s, "x0_write");
    s = nop(); s.aluop = 2'b10; s.rs1 = 5'd3; s.rs2 = 5'd3; s.rd1 = 64'd1; s.rd2 = 64'd1;
    s.rd = 5'd4; s.rw = 1'b1; s.wb_rw = 1'b1; s.wb_rd = 5'd3; s.wb_data = 64'd55;
    cycle(s, "fwd_memwb");
    check("fwd_memwb_result", bus.EX_MEM_ALU_Result, 64'd110);

    // Immediate shifts
    s = nop(); s.aluop = 2'b11; s.inst = 4'b1101; s.rd1 = -64'sd16; s.alusrc = 1'b1; s.imm = 64'd2;
    cycle(s, "srai");
    check("srai_result", bus.EX_MEM_ALU_Result, -64'sd4);
    s.inst = 4'b0101;
    cycle(s, "srli");
    check("srli_result", bus.EX_MEM_ALU_Result, 64'h3FFF_FFFF_FFFF_FFFC);

    // Branches
    s = nop(); s.branch = 1'b1; s.aluop = 2'b01; s.inst = 4'b0000; s.rd1 = 64'd9; s.rd2 = 64'd9;
    s.pc = 64'h100; s.imm = 64'd8;
    cycle(s, "beq");
    check("beq_pcsrc", 64'(bus.EX_MEM_PCSrc), 64'd1);
    check("beq_target", bus.EX_MEM_BranchTarget, 64'h110);
    check("beq_zero", 64'(bus.EX_MEM_Zero), 64'd1);
    s.inst = 4'b0100; s.rd1 = -64'sd1; s.rd2 = 64'd1;
    cycle(s, "blt");
    check("blt_pcsrc", 64'(bus.EX_MEM_PCSrc), 64'd1);
    s.inst = 4'b0101;
    cycle(s, "bge");
    check("bge_pcsrc", 64'(bus.EX_MEM_PCSrc), 64'd0);

    // Flush of a taken branch that also carries every control bit
    s = nop(); s.branch = 1'b1; s.aluop = 2'b01; s.rd1 = 64'd9; s.rd2 = 64'd9;
    s.mr = 1'b1; s.mw = 1'b1; s.rw = 1'b1; s.m2r = 1'b1; s.rd = 5'd7; s.flush = 1'b1;
    cycle(s, "flush");
    check("flush_pcsrc", 64'(bus.EX_MEM_PCSrc), 64'd0);
    check("flush_rw", 64'(bus.EX_MEM_RegWrite), 64'd0);
    s = nop(); s.rs1 = 5'd7; s.rd1 = 64'd5; s.alusrc = 1'b1; s.rd = 5'd8; s.rw = 1'b1;
    cycle(s, "after_flush");
    check("after_flush_result", bus.EX_MEM_ALU_Result, 64'd5);

    // Reset mid-stream with an ADD pending and nonzero outputs present
    s = nop(); s.rd1 = 64'd1; s.rd2 = 64'd2; s.rw = 1'b1; s.rd = 5'd6; s.mr = 1'b1;
    drive(s);
    #2 reset = 1'b0;
    #1;
    model = zeros;
    compare_all("async_reset");
    @(negedge clk);
    compare_all("held_reset");
    reset = 1'b1;
    model = ref_model(s, zeros);
    @(negedge clk);
    compare_all("post_reset");
    check("post_reset_result", bus.EX_MEM_ALU_Result, 64'd3);

    // Random instruction stream
    for (int i = 0; i < 400; i++) cycle(rand_stim(), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
